pc_fetch_unit: RTL and testbench

//   IF-stage PC generator and IF/ID register. It consumes the 2-bit PCSel from the ID-stage PC select logic
//   and drives the synchronous-read IMEM address. It holds the PC register and squashes the wrong-path

---
 rtl/pc_fetch_unit.sv | 69 ++++++
 tb/tb_pc_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// IF-stage PC generator plus IF/ID pipeline register feeding a 1-cycle synchronous-read IMEM.
// Latency: imem_addr is combinational; an instruction reaches ID one edge after its address; redirect costs one bubble.
// Backpressure: stall freezes the PC, the IF/ID register and the redirect counter; the BRAM re-reads pc_q so dout holds.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jal_target,
    input  logic [31:0] alu_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic [31:0] redirect_count
);

    localparam logic [1:0] SEL_JAL  = 2'b01;
    localparam logic [1:0] SEL_JALR = 2'b10;

    // Address whose data is currently on imem_dout.
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        redirect;

    assign redirect = !stall && ((pc_sel == SEL_JAL) || (pc_sel == SEL_JALR));

    always_comb begin
        pc_next = pc_q + 32'd4;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (pc_sel == SEL_JAL) begin
            pc_next = jal_target;
        end else if (pc_sel == SEL_JALR) begin
            pc_next = {alu_target[31:1], 1'b0};
        end
    end

    assign imem_addr = pc_next;

    // On redirect the word at pc_q is wrong-path, so ID sees a NOP bubble instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            id_pc          <= 32'd0;
            id_instr       <= NOP_INSTR;
            id_valid       <= 1'b0;
            redirect_count <= 32'd0;
        end else if (!stall) begin
            pc_q  <= pc_next;
            id_pc <= pc_q;
            if (redirect) begin
                id_instr       <= NOP_INSTR;
                id_valid       <= 1'b0;
                redirect_count <= redirect_count + 32'd1;
            end else begin
                id_instr <= imem_dout;
                id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural 1-cycle-latency IMEM.
// IMEM content is a fixed function of the address so every expected word is computable here.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] jal_target;
    logic [31:0] alu_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] redirect_count;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .jal_target     (jal_target),
        .alu_target     (alu_target),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) imem_dout <= mem(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic v, input logic [31:0] cnt);
        chk({tag, "_pc"},    id_pc,          pc);
        chk({tag, "_instr"}, id_instr,       instr);
        chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, v});
        chk({tag, "_cnt"},   redirect_count, cnt);
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        pc_sel     = 2'b00;
        jal_target = 32'd0;
        alu_target = 32'd0;
        #1;
        chk("addr_in_rst", imem_addr, 32'h4000_0000);
        tick();
        tick();
        chk_id("reset", 32'd0, 32'h13, 1'b0, 32'd0);
        chk("addr_in_rst2", imem_addr, 32'h4000_0000);

        // Release reset and free-run
        rst = 1'b0;
        #1;
        chk("addr_after_rst", imem_addr, 32'h4000_0004);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_id("run", 32'h4000_0000 + 32'(4 * i), mem(32'h4000_0000 + 32'(4 * i)), 1'b1, 32'd0);
            chk("run_lead", imem_addr, 32'h4000_0008 + 32'(4 * i));
        end

        // JAL redirect
        pc_sel     = 2'b01;
        jal_target = 32'h4000_0100;
        #1;
        chk("jal_addr", imem_addr, 32'h4000_0100);
        tick();
        chk_id("jal_bubble", 32'h4000_0010, 32'h13, 1'b0, 32'd1);
        pc_sel = 2'b00;
        tick();
        chk_id("jal_tgt", 32'h4000_0100, mem(32'h4000_0100), 1'b1, 32'd1);

        // JALR/branch redirect, bit0 cleared, bit1 kept
        pc_sel     = 2'b10;
        alu_target = 32'h4000_0203;
        #1;
        chk("alu_addr", imem_addr, 32'h4000_0202);
        tick();
        chk_id("alu_bubble", 32'h4000_0104, 32'h13, 1'b0, 32'd2);
        pc_sel = 2'b00;
        tick();
        chk_id("alu_tgt", 32'h4000_0202, mem(32'h4000_0202), 1'b1, 32'd2);
        chk("alu_seq_addr", imem_addr, 32'h4000_020A);

        // Stall with a pending redirect
        stall      = 1'b1;
        pc_sel     = 2'b10;
        alu_target = 32'h4000_0300;
        #1;
        chk("stall_addr", imem_addr, 32'h4000_0206);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_id("stall", 32'h4000_0202, mem(32'h4000_0202), 1'b1, 32'd2);
            chk("stall_addr_hold", imem_addr, 32'h4000_0206);
        end
        stall = 1'b0;
        #1;
        chk("unstall_addr", imem_addr, 32'h4000_0300);
        tick();
        chk_id("unstall_bubble", 32'h4000_0206, 32'h13, 1'b0, 32'd3);
        pc_sel = 2'b00;
        tick();
        chk_id("unstall_tgt", 32'h4000_0300, mem(32'h4000_0300), 1'b1, 32'd3);

        // Reserved select behaves as sequential
        pc_sel     = 2'b11;
        jal_target = 32'h4000_0500;
        alu_target = 32'h4000_0600;
        #1;
        chk("sel11_addr", imem_addr, 32'h4000_0308);
        tick();
        chk_id("sel11", 32'h4000_0304, mem(32'h4000_0304), 1'b1, 32'd3);

        // Reset during a redirect edge
        pc_sel = 2'b01;
        rst    = 1'b1;
        #1;
        chk("rst_redir_addr", imem_addr, 32'h4000_0000);
        tick();
        chk_id("rst_redir", 32'd0, 32'h13, 1'b0, 32'd0);
        rst    = 1'b0;
        pc_sel = 2'b00;
        tick();
        chk_id("rst_resume", 32'h4000_0000, mem(32'h4000_0000), 1'b1, 32'd0);

        // PC+4 wraps modulo 2^32
        pc_sel     = 2'b01;
        jal_target = 32'hFFFF_FFFC;
        tick();
        pc_sel = 2'b00;
        #1;
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        tick();
        chk_id("wrap_tgt", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
